hangman_round_ctrl: RTL and testbench

Parametrised round controller for the hangman game. It replaces the ad-hoc guess tracking and the wrong-guess counter clocked off a signal edge with one fully synchronous block. It takes decoded letter guesses from the keyboard/decoder path and the word's letter mask from level selection, then tracks guessed and revealed letters, remaining lives, round outcome and a saturating win tally. Its outputs drive the VGA renderer and the HEX displays.

---
 rtl/hangman_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_hangman_round_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: tracks guessed letters, lives and round outcome
// for one word at a time, and keeps a saturating tally of rounds won.
// Every update happens on the rising clock edge. The per-guess result pulses
// are registered, so they appear the cycle after the guess is presented.
module hangman_round_ctrl #(
   parameter int ALPHA    = 26,
   parameter int LETTER_W = 5,
   parameter int LIVES    = 4,
   parameter int LIVES_W  = 3,
   parameter int SCORE_W  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ALPHA-1:0]    word_mask,
   input  logic                guess_valid,
   input  logic [LETTER_W-1:0] guess_letter,
   output logic                guess_ready,
   output logic [ALPHA-1:0]    revealed,
   output logic [ALPHA-1:0]    guessed,
   output logic [LIVES_W-1:0]  lives_left,
   output logic [1:0]          state,
   output logic                hit,
   output logic                miss,
   output logic                dup,
   output logic                bad,
   output logic [SCORE_W-1:0]  wins
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN  = 2'd2,
      LOSE = 2'd3
   } state_t;

   localparam logic [LETTER_W:0]  ALPHA_CODE = (LETTER_W+1)'(ALPHA);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

   state_t               r_state;
   logic [ALPHA-1:0]     r_mask;
   logic [ALPHA-1:0]     r_guessed;
   logic [LIVES_W-1:0]   r_lives;
   logic [SCORE_W-1:0]   r_wins;
   logic                 r_hit;
   logic                 r_miss;
   logic                 r_dup;
   logic                 r_bad;

   state_t               w_stateNext;
   logic [ALPHA-1:0]     w_maskNext;
   logic [ALPHA-1:0]     w_guessedNext;
   logic [LIVES_W-1:0]   w_livesNext;
   logic [SCORE_W-1:0]   w_winsNext;
   logic                 w_hitNext;
   logic                 w_missNext;
   logic                 w_dupNext;
   logic                 w_badNext;

   logic [ALPHA-1:0]     w_letterBit;
   logic                 w_letterOk;
   logic [ALPHA-1:0]     w_guessedHit;
   logic [SCORE_W-1:0]   w_winsInc;

   // One-hot of the guessed letter; shifting past the top leaves it all-zero,
   // and out-of-range codes are caught by w_letterOk before it is used.
   assign w_letterBit  = ALPHA'(1) << guess_letter;
   assign w_letterOk   = ({1'b0, guess_letter} < ALPHA_CODE);
   assign w_guessedHit = r_guessed | w_letterBit;
   assign w_winsInc    = (&r_wins) ? r_wins : r_wins + SCORE_W'(1);

   // Next-state and next-register values; everything holds unless changed.
   always_comb begin
      w_stateNext   = r_state;
      w_maskNext    = r_mask;
      w_guessedNext = r_guessed;
      w_livesNext   = r_lives;
      w_winsNext    = r_wins;
      w_hitNext     = 1'b0;
      w_missNext    = 1'b0;
      w_dupNext     = 1'b0;
      w_badNext     = 1'b0;

      if (start) begin
         // A new round always wins over a guess arriving in the same cycle.
         w_maskNext    = word_mask;
         w_guessedNext = '0;
         w_livesNext   = LIVES_INIT;
         w_stateNext   = PLAY;
      end else if (r_state == PLAY) begin
         if (r_mask == '0) begin
            // The empty word is solved immediately. Any guess that arrives in
            // this cycle is dropped so that the round ends cleanly.
            w_stateNext = WIN;
            w_winsNext  = w_winsInc;
         end else if (guess_valid) begin
            if (!w_letterOk) begin
               w_badNext = 1'b1;
            end else if ((r_guessed & w_letterBit) != '0) begin
               w_dupNext = 1'b1;
            end else if ((r_mask & w_letterBit) != '0) begin
               w_guessedNext = w_guessedHit;
               w_hitNext     = 1'b1;
               if ((w_guessedHit & r_mask) == r_mask) begin
                  w_stateNext = WIN;
                  w_winsNext  = w_winsInc;
               end
            end else begin
               w_guessedNext = w_guessedHit;
               w_missNext    = 1'b1;
               if (r_lives <= LIVES_W'(1)) begin
                  w_livesNext = '0;
                  w_stateNext = LOSE;
               end else begin
                  w_livesNext = r_lives - LIVES_W'(1);
               end
            end
         end
      end
   end

   // Register bank; reset asserts asynchronously and releases on the clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_mask    <= '0;
         r_guessed <= '0;
         r_lives   <= LIVES_INIT;
         r_wins    <= '0;
         r_hit     <= 1'b0;
         r_miss    <= 1'b0;
         r_dup     <= 1'b0;
         r_bad     <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_mask    <= w_maskNext;
         r_guessed <= w_guessedNext;
         r_lives   <= w_livesNext;
         r_wins    <= w_winsNext;
         r_hit     <= w_hitNext;
         r_miss    <= w_missNext;
         r_dup     <= w_dupNext;
         r_bad     <= w_badNext;
      end
   end

   assign guess_ready = (r_state == PLAY);
   assign revealed    = r_guessed & r_mask;
   assign guessed     = r_guessed;
   assign lives_left  = r_lives;
   assign state       = r_state;
   assign hit         = r_hit;
   assign miss        = r_miss;
   assign dup         = r_dup;
   assign bad         = r_bad;
   assign wins        = r_wins;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Bench for hangman_round_ctrl: directed rounds plus random rounds, checked
// against a letter-set model. Guess results go through a scoreboard queue
// that a separate monitor drains whenever the DUT raises a result pulse.
module tb_hangman_round_ctrl;

   localparam int ALPHA    = 26;
   localparam int LETTER_W = 5;
   localparam int LIVES    = 4;
   localparam int LIVES_W  = 3;
   localparam int SCORE_W  = 4;
   localparam int WINS_MAX = (1 << SCORE_W) - 1;

   logic                clk = 1'b0;
   logic                reset_n = 1'b1;
   logic                start = 1'b0;
   logic [ALPHA-1:0]    word_mask = '0;
   logic                guess_valid = 1'b0;
   logic [LETTER_W-1:0] guess_letter = '0;
   logic                guess_ready;
   logic [ALPHA-1:0]    revealed;
   logic [ALPHA-1:0]    guessed;
   logic [LIVES_W-1:0]  lives_left;
   logic [1:0]          state;
   logic                hit, miss, dup, bad;
   logic [SCORE_W-1:0]  wins;

   hangman_round_ctrl #(
      .ALPHA(ALPHA), .LETTER_W(LETTER_W), .LIVES(LIVES),
      .LIVES_W(LIVES_W), .SCORE_W(SCORE_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .word_mask(word_mask),
      .guess_valid(guess_valid), .guess_letter(guess_letter),
      .guess_ready(guess_ready), .revealed(revealed), .guessed(guessed),
      .lives_left(lives_left), .state(state), .hit(hit), .miss(miss),
      .dup(dup), .bad(bad), .wins(wins)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]         pulses;
      logic [1:0]         state;
      logic [LIVES_W-1:0] lives;
      logic [ALPHA-1:0]   guessed;
      logic [ALPHA-1:0]   revealed;
      logic [SCORE_W-1:0] wins;
   } exp_t;

   exp_t sbq[$];
   int   nVectors = 0;
   int   nMiscompares = 0;

   // Reference model: the word as a set of letters, the set of tried letters,
   // a count of word letters found so far, lives, wins and the round outcome.
   bit   inWord[ALPHA];
   bit   tried[ALPHA];
   int   wordSize = 0;
   int   found = 0;
   int   mLives = LIVES;
   int   mWins = 0;
   int   mState = 0;

   function automatic logic [ALPHA-1:0] triedVec();
      logic [ALPHA-1:0] v;
      for (int i = 0; i < ALPHA; i++) v[i] = tried[i];
      return v;
   endfunction

   function automatic logic [ALPHA-1:0] revealedVec();
      logic [ALPHA-1:0] v;
      for (int i = 0; i < ALPHA; i++) v[i] = tried[i] && inWord[i];
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < ALPHA; i++) begin
         inWord[i] = 1'b0;
         tried[i]  = 1'b0;
      end
      wordSize = 0;
      found    = 0;
      mLives   = LIVES;
      mWins    = 0;
      mState   = 0;
   endtask

   task automatic modelWin();
      mState = 2;
      if (mWins < WINS_MAX) mWins++;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_state"}, 64'(state), 64'(mState));
      check({tag, "_lives"}, 64'(lives_left), 64'(mLives));
      check({tag, "_guessed"}, 64'(guessed), 64'(triedVec()));
      check({tag, "_revealed"}, 64'(revealed), 64'(revealedVec()));
      check({tag, "_wins"}, 64'(wins), 64'(mWins));
      check({tag, "_ready"}, 64'(guess_ready), 64'(mState == 1));
   endtask

   // Start a round, optionally with a guess in the same cycle (must be dropped).
   task automatic applyStimulus_start(input logic [ALPHA-1:0] mask, input bit withGuess,
                                      input int letter);
      wordSize = 0;
      found    = 0;
      for (int i = 0; i < ALPHA; i++) begin
         inWord[i] = mask[i];
         tried[i]  = 1'b0;
         if (mask[i]) wordSize++;
      end
      mLives = LIVES;
      mState = 1;
      start        = 1'b1;
      word_mask    = mask;
      guess_valid  = withGuess;
      guess_letter = LETTER_W'(letter);
      @(posedge clk);
      #1;
      start       = 1'b0;
      guess_valid = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("start");
      check("start_pulses", 64'({hit, miss, dup, bad}), 64'(0));
      if (wordSize == 0) begin
         @(posedge clk);
         #1;
         modelWin();
         checkOutput("empty_win");
      end
   endtask

   // Present one guess; accepted guesses push their expected result.
   task automatic applyStimulus_guess(input int letter);
      exp_t e;
      bit   accepted;
      accepted = (mState == 1);
      if (accepted) begin
         if (letter >= ALPHA) begin
            e.pulses = 4'b0001;
         end else if (tried[letter]) begin
            e.pulses = 4'b0010;
         end else if (inWord[letter]) begin
            e.pulses = 4'b1000;
            tried[letter] = 1'b1;
            found++;
            if (found == wordSize) modelWin();
         end else begin
            e.pulses = 4'b0100;
            tried[letter] = 1'b1;
            mLives--;
            if (mLives == 0) mState = 3;
         end
         e.state    = 2'(mState);
         e.lives    = LIVES_W'(mLives);
         e.guessed  = triedVec();
         e.revealed = revealedVec();
         e.wins     = SCORE_W'(mWins);
         sbq.push_back(e);
      end
      guess_letter = LETTER_W'(letter);
      guess_valid  = 1'b1;
      @(posedge clk);
      #1;
      guess_valid = 1'b0;
      @(negedge clk);
      #1;
      if (accepted) begin
         check("result_seen", 64'(sbq.size()), 64'(0));
         sbq.delete();
      end else begin
         check("ignored_pulses", 64'({hit, miss, dup, bad}), 64'(0));
         checkOutput("ignored");
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset_n && (hit || miss || dup || bad)) begin
         if (sbq.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL unexpected_pulse at %0t: got hmdb=%b, expected none",
                     $time, {hit, miss, dup, bad});
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("mon_pulses", 64'({hit, miss, dup, bad}), 64'(e.pulses));
            check("mon_state", 64'(state), 64'(e.state));
            check("mon_lives", 64'(lives_left), 64'(e.lives));
            check("mon_guessed", 64'(guessed), 64'(e.guessed));
            check("mon_revealed", 64'(revealed), 64'(e.revealed));
            check("mon_wins", 64'(wins), 64'(e.wins));
         end
      end
   end

   // Directed scenarios, random rounds, saturation and asynchronous reset.
   initial begin
      logic [ALPHA-1:0] cat;
      logic [ALPHA-1:0] rmask;
      int               letter;
      cat = '0;
      cat[0]  = 1'b1;
      cat[2]  = 1'b1;
      cat[19] = 1'b1;
      modelReset();

      #2 reset_n = 1'b0;
      #1;
      checkOutput("reset");
      check("reset_pulses", 64'({hit, miss, dup, bad}), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(2);
      applyStimulus_guess(0);

      // Win C-A-T.
      applyStimulus_start(cat, 1'b0, 0);
      applyStimulus_guess(0);
      applyStimulus_guess(2);
      applyStimulus_guess(19);
      checkOutput("cat_win");

      // Lose with four misses, then a guess that must be ignored.
      applyStimulus_start(cat, 1'b0, 0);
      applyStimulus_guess(25);
      applyStimulus_guess(16);
      applyStimulus_guess(23);
      applyStimulus_guess(9);
      checkOutput("cat_lose");
      applyStimulus_guess(0);

      // Duplicate and out-of-range guesses.
      applyStimulus_start(cat, 1'b0, 0);
      applyStimulus_guess(0);
      applyStimulus_guess(0);
      applyStimulus_guess(27);
      checkOutput("dup_bad");

      // Start and guess together, then the empty word.
      applyStimulus_start(cat, 1'b1, 2);
      applyStimulus_start('0, 1'b0, 0);
      applyStimulus_guess(5);

      // Random rounds, including restarts in the middle of a round.
      for (int r = 0; r < 30; r++) begin
         rmask = ALPHA'($urandom & $urandom & $urandom);
         applyStimulus_start(rmask, 1'($urandom_range(0, 5) == 0), $urandom_range(0, 31));
         for (int g = 0; g < 14; g++) begin
            letter = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1 && wordSize > 0) begin
               letter = letter % ALPHA;
               while (!inWord[letter]) letter = (letter + 1) % ALPHA;
            end
            applyStimulus_guess(letter);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
         end
      end

      // Saturate the win tally from a clean reset.
      reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("reset2");
      @(negedge clk);
      reset_n = 1'b1;
      for (int r = 0; r < WINS_MAX + 2; r++) begin
         letter = $urandom_range(0, ALPHA - 1);
         rmask = '0;
         rmask[letter] = 1'b1;
         applyStimulus_start(rmask, 1'b0, 0);
         applyStimulus_guess(letter);
      end
      check("wins_saturated", 64'(wins), 64'(WINS_MAX));

      // Asynchronous reset in the middle of a round, away from any clock edge.
      applyStimulus_start(cat, 1'b0, 0);
      applyStimulus_guess(0);
      applyStimulus_guess(7);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      modelReset();
      check("async_state", 64'(state), 64'(0));
      check("async_lives", 64'(lives_left), 64'(LIVES));
      check("async_wins", 64'(wins), 64'(0));
      check("async_guessed", 64'(guessed), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(2);
      checkOutput("after_reset");

      check("queue_empty", 64'(sbq.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
